// File: rtl/mag_square_stage_pkg.sv
// Shared constants for the magnitude-squared and square-root stages.
package mag_square_stage_pkg;

  localparam int unsigned IN_WIDTH_DEF  = 16;
  localparam int unsigned OUT_WIDTH_DEF = 32;
  localparam int unsigned FRAME_LEN_DEF = 1024;
  localparam int unsigned IDX_W_DEF     = 10;

  // Largest radicand representable at the default output width.
  localparam logic [OUT_WIDTH_DEF-1:0] RAD_SAT_MAX = '1;

endpackage

// File: rtl/mag_square_stage.sv
// Two-stage re^2 + im^2 pipeline with per-frame bin index tracking and a
// sticky frame-length error flag.
module mag_square_stage
  import mag_square_stage_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = IN_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned IDX_W     = IDX_W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_re,
  input  logic [IN_WIDTH-1:0]  in_im,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_radicand,
  output logic [IDX_W-1:0]     out_index,
  output logic                 out_last,
  output logic                 frame_err
);

  localparam int unsigned PW = 2 * IN_WIDTH;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned CW = (SW > OUT_WIDTH) ? SW : OUT_WIDTH;
  localparam logic [OUT_WIDTH-1:0] SAT_MAX  = '1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic                 en;
  logic                 in_xfer;
  logic signed [PW-1:0] re_x;
  logic signed [PW-1:0] im_x;
  logic [PW-1:0]        re_sq_d;
  logic [PW-1:0]        im_sq_d;
  logic [SW-1:0]        sum;
  logic [CW-1:0]        sum_c;
  logic [OUT_WIDTH-1:0] rad_d;
  logic [IDX_W-1:0]     cnt_d;
  logic                 err_d;

  logic                 s1_valid_q;
  logic                 s1_last_q;
  logic [PW-1:0]        re_sq_q;
  logic [PW-1:0]        im_sq_q;
  logic [IDX_W-1:0]     s1_idx_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [OUT_WIDTH-1:0] rad_q;
  logic [IDX_W-1:0]     out_idx_q;
  logic [IDX_W-1:0]     cnt_q;
  logic                 frame_err_q;

  assign en       = out_ready | ~out_valid_q;
  assign in_ready = en;
  assign in_xfer  = in_valid & en;

  always_comb begin
    re_x    = {{IN_WIDTH{in_re[IN_WIDTH-1]}}, in_re};
    im_x    = {{IN_WIDTH{in_im[IN_WIDTH-1]}}, in_im};
    re_sq_d = re_x * re_x;
    im_sq_d = im_x * im_x;
  end

  // Widen to whichever is larger so the saturation compare works for any OUT_WIDTH.
  always_comb begin
    sum   = {1'b0, re_sq_q} + {1'b0, im_sq_q};
    sum_c = CW'(sum);
    rad_d = (sum_c > CW'(SAT_MAX)) ? SAT_MAX : sum_c[OUT_WIDTH-1:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = frame_err_q;
    if (in_xfer) begin
      if (in_last) begin
        cnt_d = '0;
        if (cnt_q != LAST_IDX) err_d = 1'b1;
      end else if (cnt_q == LAST_IDX) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      re_sq_q     <= '0;
      im_sq_q     <= '0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      rad_q       <= '0;
      out_idx_q   <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_err_q <= err_d;
      if (en) begin
        s1_valid_q  <= in_valid;
        s1_last_q   <= in_last;
        re_sq_q     <= re_sq_d;
        im_sq_q     <= im_sq_d;
        s1_idx_q    <= cnt_q;
        out_valid_q <= s1_valid_q;
        out_last_q  <= s1_last_q;
        rad_q       <= rad_d;
        out_idx_q   <= s1_idx_q;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_radicand = rad_q;
  assign out_index    = out_idx_q;
  assign out_last     = out_last_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_mag_square_stage.sv
// Self-checking bench: directed vectors, frame/stall/reset sequences and a
// randomized phase checked against a queue-based reference model.
module tb_mag_square_stage;

  localparam int unsigned IW = 16;
  localparam int unsigned OW = 32;
  localparam int unsigned FL = 1024;
  localparam int unsigned XW = 10;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [IW-1:0] in_re = '0;
  logic signed [IW-1:0] in_im = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_last;
  logic                 frame_err;
  logic [OW-1:0]        out_radicand;
  logic [XW-1:0]        out_index;

  logic                 in_ready30;
  logic                 out_valid30;
  logic                 out_last30;
  logic                 frame_err30;
  logic [29:0]          out_radicand30;
  logic [XW-1:0]        out_index30;

  mag_square_stage #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .FRAME_LEN(FL), .IDX_W(XW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_radicand(out_radicand), .out_index(out_index),
    .out_last(out_last), .frame_err(frame_err)
  );

  mag_square_stage #(.IN_WIDTH(IW), .OUT_WIDTH(30), .FRAME_LEN(FL), .IDX_W(XW)) dut30 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready30),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .out_valid(out_valid30),
    .out_ready(out_ready), .out_radicand(out_radicand30), .out_index(out_index30),
    .out_last(out_last30), .frame_err(frame_err30)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] rad;
    logic [29:0]   rad30;
    int unsigned   idx;
    bit            last;
  } exp_t;

  typedef struct {
    int            re;
    int            im;
    logic [OW-1:0] rad;
    logic [29:0]   rad30;
  } vec_t;

  exp_t        q[$];
  exp_t        e;
  longint      s;
  int unsigned m_idx = 0;
  bit          m_err = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          n_out = 0;
  int          n_last = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference model: sum of squares in plain integer arithmetic, bin index
  // counted per frame from the accepted-sample stream.
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      m_idx = 0;
      m_err = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, out_ready || !out_valid);
      chk("frame_err", frame_err, m_err);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk("radicand", out_radicand, q[0].rad);
          chk("radicand30", out_radicand30, q[0].rad30);
          chk("out_valid30", out_valid30, 1);
          chk("index", out_index, q[0].idx);
          chk("last", out_last, q[0].last);
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
            if (out_last) n_last++;
          end
        end
      end
      if (in_valid && in_ready) begin
        s = longint'(in_re) * longint'(in_re) + longint'(in_im) * longint'(in_im);
        e.rad   = (s > 64'sd4294967295) ? '1 : OW'(s);
        e.rad30 = (s > 64'sd1073741823) ? '1 : 30'(s);
        e.idx   = m_idx;
        e.last  = in_last;
        q.push_back(e);
        if (in_last) begin
          if (m_idx != FL - 1) m_err = 1'b1;
          m_idx = 0;
        end else if (m_idx == FL - 1) begin
          m_err = 1'b1;
          m_idx = 0;
        end else begin
          m_idx = m_idx + 1;
        end
      end
    end
  end

  task automatic do_reset(input int n);
    rstn = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_radicand", out_radicand, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    rstn = 1'b1;
  endtask

  task automatic step(input bit v, input bit last, input bit ordy, output bit acc, output bit rdy);
    in_valid = v;
    in_last = last;
    out_ready = ordy;
    in_re = IW'($urandom);
    in_im = IW'($urandom);
    @(negedge clk);
    rdy = in_ready;
    acc = v && rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_stream(input int n, input int last_at);
    int k = 0;
    int budget = n * 4 + 20;
    bit acc, rdy;
    while (k < n && budget > 0) begin
      step(1'b1, k == last_at, 1'b1, acc, rdy);
      if (acc) k++;
      budget--;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    if (k < n) chk("stream_timeout", k, n);
  endtask

  task automatic drain();
    int budget = 12;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  vec_t vecs[8];

  initial begin
    bit acc, rdy;
    int base_out, base_last;

    vecs[0] = '{3, -4, 32'd25, 30'd25};
    vecs[1] = '{-32768, -32768, 32'h8000_0000, 30'h3FFF_FFFF};
    vecs[2] = '{0, 0, 32'd0, 30'd0};
    vecs[3] = '{32767, 32767, 32'h7FFE_0002, 30'h3FFF_FFFF};
    vecs[4] = '{-32768, 0, 32'h4000_0000, 30'h3FFF_FFFF};
    vecs[5] = '{32767, 0, 32'h3FFF_0001, 30'h3FFF_0001};
    vecs[6] = '{1, -1, 32'd2, 30'd2};
    vecs[7] = '{-1000, 300, 32'd1090000, 30'd1090000};

    do_reset(3);

    // Isolated samples: exact two-cycle latency and saturation behaviour.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_last = 1'b0;
      in_re = IW'(vecs[i].re);
      in_im = IW'(vecs[i].im);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("lat1_valid", out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat2_valid", out_valid, 1);
      chk("vec_radicand", out_radicand, vecs[i].rad);
      chk("vec_radicand30", out_radicand30, vecs[i].rad30);
      @(posedge clk);
      #1;
    end
    drain();

    // Full well-formed frame.
    do_reset(1);
    base_out = n_out;
    base_last = n_last;
    send_stream(FL, FL - 1);
    drain();
    chk("frame_count", n_out - base_out, FL);
    chk("frame_lasts", n_last - base_last, 1);
    chk("frame_ok_err", frame_err, 0);

    // Missing in_last at the final bin: wrap to 0 and flag.
    do_reset(1);
    send_stream(FL + 1, -1);
    drain();
    chk("wrap_err", frame_err, 1);

    // Short frame: in_last on the 10th sample.
    do_reset(1);
    send_stream(10, 9);
    drain();
    chk("short_err", frame_err, 1);
    send_stream(5, -1);
    drain();
    chk("short_err_sticky", frame_err, 1);

    // Downstream stall for 5 cycles mid-stream.
    do_reset(1);
    for (int c = 0; c < 30; c++) begin
      step(1'b1, 1'b0, !(c >= 10 && c < 15), acc, rdy);
      if (c >= 10 && c < 15) chk("stall_in_ready", rdy, 0);
    end
    drain();

    // Reset with two samples in flight.
    do_reset(1);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b1, acc, rdy);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_no_stale", out_valid, 0);
    send_stream(1, -1);
    drain();

    // Randomized traffic with occasional frame ends.
    do_reset(1);
    for (int c = 0; c < 2000; c++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0, acc, rdy);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mag_square_stage.md
MAG_SQUARE_STAGE -- requirements
Module: mag_square_stage

Interface
REQ-001 Parameter IN_WIDTH, default 16, width of signed real/imaginary input samples.
REQ-002 Parameter OUT_WIDTH, default 32, width of unsigned radicand output fed to the square-root stage.
REQ-003 Parameter FRAME_LEN, default 1024, samples per frame; power of two, >= 4.
REQ-004 Parameter IDX_W, default 10, index width, equal to log2(FRAME_LEN).
REQ-005 clk  in  1  clock; all logic on posedge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 in_valid  in  1  input sample present.
REQ-008 in_ready  out  1  stage accepts input this cycle.
REQ-009 in_re  in  IN_WIDTH  signed real part.
REQ-010 in_im  in  IN_WIDTH  signed imaginary part.
REQ-011 in_last  in  1  marks last sample of frame.
REQ-012 out_valid  out  1  radicand present.
REQ-013 out_ready  in  1  downstream accepts radicand.
REQ-014 out_radicand  out  OUT_WIDTH  re^2 + im^2, unsigned.
REQ-015 out_index  out  IDX_W  bin index of this radicand within its frame.
REQ-016 out_last  out  1  in_last carried with the sample.
REQ-017 frame_err  out  1  sticky; frame length mismatch detected.

Function
REQ-018 Input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-019 Two-stage pipeline: stage 1 registers re^2 and im^2; stage 2 registers the sum together with index and last.
REQ-020 Pipeline enable en = out_ready OR NOT out_valid; all stages advance only when en=1 and hold otherwise.
REQ-021 in_ready = en (combinational); in_ready never depends on in_valid.
REQ-022 Latency: an accepted sample appears on out_valid exactly 2 cycles later when en stays 1.
REQ-023 Throughput: one sample per cycle with out_ready held 1.
REQ-024 Bubbles propagate: a stage's valid bit loads the previous stage's valid (or the input handshake) when en=1.
REQ-025 Squares use full signed products of 2*IN_WIDTH bits; the sum uses 2*IN_WIDTH+1 bits.
REQ-026 If the sum exceeds 2^OUT_WIDTH-1, out_radicand saturates to 2^OUT_WIDTH-1; otherwise it is zero-extended.
REQ-027 Index counter increments on each input transfer and travels down the pipeline with the sample.
REQ-028 An input transfer with in_last=1 resets the counter to 0 for the next sample.
REQ-029 If in_last=1 arrives at an index other than FRAME_LEN-1, frame_err is set.
REQ-030 If a sample at index FRAME_LEN-1 arrives with in_last=0, the counter wraps to 0 and frame_err is set.
REQ-031 frame_err clears only on reset.
REQ-032 While stalled, out_radicand, out_index and out_last are held stable.

Reset
REQ-033 When rstn=0 at a clock edge: all valid bits, out_valid, out_radicand, out_index, out_last, frame_err and the index counter are cleared to 0.
REQ-034 A reset mid-frame discards in-flight samples; the next accepted sample has index 0.
REQ-035 in_ready is 1 during and after reset, because out_valid is 0.

Structure
REQ-036 A shared package holds IN_WIDTH/OUT_WIDTH defaults and the saturation maximum constant, for reuse by the square-root stage.
REQ-037 No sub-module is needed; the squarer is inferred inline and maps to DSP multipliers.

Verification
REQ-038 Sample re=3, im=-4, out_ready=1 -> out_radicand=25, out_valid exactly 2 cycles after acceptance.
REQ-039 Sample re=-32768, im=-32768 -> out_radicand=0x80000000 with no saturation; same sample with OUT_WIDTH=30 -> 0x3FFFFFFF.
REQ-040 Stream of 1024 samples with in_last on the 1024th, out_ready=1 -> out_index 0..1023, out_last on index 1023, frame_err=0.
REQ-041 out_ready=0 for 5 cycles mid-stream -> in_ready=0 after the pipeline fills; outputs held; no sample lost or duplicated.
REQ-042 in_last on sample 10 -> frame_err=1 and sticky; next sample has index 0.
REQ-043 rstn=0 for 1 cycle with 2 samples in flight -> out_valid=0, no stale output; next sample has index 0.
